pacman_motion_ctrl: RTL and testbench
=====================================

Name: pacman_motion_ctrl

Overview:
- Sprite movement controller for the Pac-Man VGA datapath, successor to the fixed-step block controller.
- Runs on the master clock and advances the sprite only on a one-cycle `tick` enable.
- Buffers the most recent turn request until the maze legality checker permits it, and continues along the current heading otherwise.
- Supports parametrised step size, playfield bounds, start position and edge mode (clamp or tunnel wrap). Outputs sprite origin and facing to the sprite ROM / rgb mux.

Parameters:
- H_MIN, 150, leftmost legal sprite x (pixel column)
- H_MAX, 630, right playfield edge; max sprite x = H_MAX-SPRITE
- V_MIN, 34, topmost legal sprite y
- V_MAX, 514, bottom playfield edge; max sprite y = V_MAX-SPRITE
- SPRITE, 30, sprite width/height in pixels
- STEP, 2, pixels moved per accepted tick (1..8)
- START_X, 360, reset x
- START_Y, 154, reset y
- WRAP_EN, 0, 0 = clamp at edges, 1 = wrap to opposite edge (tunnel)

Ports:
- clk  in  1  master clock
- rst  in  1  asynchronous active-high reset
- tick  in  1  movement enable, one clk wide
- freeze  in  1  pause: ticks ignored, requests still latched
- up, down, left, right  in  1 each  direction buttons (debounced, level)
- leg_l, leg_r, leg_u, leg_d  in  1 each  legality of a STEP move from current position
- pm_xpos  out  10  sprite top-left x
- pm_ypos  out  10  sprite top-left y
- heading  out  2  current direction: 0 R, 1 L, 2 U, 3 D
- moveleft  out  1  sprite mirror select (1 = facing left)
- moving  out  1  1 while in MOVING state
- step_done  out  1  one-cycle pulse on every tick that changed position

Behaviour:
- Reset (async, any time, including mid-step) sets:
  - pm_xpos=START_X, pm_ypos=START_Y
  - heading=0, moveleft=0, moving=0, step_done=0
  - req_valid=0, state=IDLE
- Request capture, every clk:
  - Button priority is right > left > up > down.
  - Any press loads req_dir and sets req_valid=1.
  - A newer press overwrites a pending request.
  - No press leaves the pending request unchanged.
- Effective request in a given cycle = that cycle's press if any, otherwise the stored req_dir/req_valid. A press coincident with tick is acted on in that tick.
- `leg(d)` denotes the legality input for direction d.
- States are IDLE, MOVING, BLOCKED. Evaluation happens only when tick=1 and freeze=0; otherwise state, position and heading hold.
- IDLE:
  - Effective request valid and leg(req) -> heading=req, step, clear req_valid, go to MOVING.
  - Otherwise stay in IDLE.
- MOVING:
  - Effective request valid and leg(req) -> heading=req, step, clear req_valid.
  - Else leg(heading) -> step along heading; request stays pending.
  - Else -> BLOCKED, no step.
- BLOCKED:
  - Same rule as MOVING's first two cases; any step returns to MOVING.
  - No legal move -> stay in BLOCKED.
- moving=1 only in MOVING.
- step_done pulses the cycle after a position change, and is 0 if clamping left position unchanged.
- moveleft: set to 1 when heading becomes L, to 0 when heading becomes R; unchanged for U/D.
- Step arithmetic uses 11-bit intermediates, with no unsigned underflow.
  - R: x+STEP. L: x-STEP. U: y-STEP. D: y+STEP.
- Boundary handling, WRAP_EN=0 (clamp):
  - x is limited to [H_MIN, H_MAX-SPRITE] and y to [V_MIN, V_MAX-SPRITE].
  - A step that would exceed a bound lands exactly on the bound.
- Boundary handling, WRAP_EN=1:
  - R past the max x -> x=H_MIN; L below H_MIN -> x=H_MAX-SPRITE.
  - U and D wrap the same way on y.
- Legality inputs are sampled on the tick cycle and must be valid for the current registered position.
- freeze=1 on a tick cycle: the tick is dropped, not deferred.

Test Plan:
- Reset, then pulse right for 1 clk with leg_r=1, then 5 ticks (STEP=2) -> x=360,362,364,366,368,370; heading=0; moving=1; 5 step_done pulses.
- While moving R, press up once with leg_u=0 for 3 ticks, then leg_u=1 -> x advances 6 px, then the next tick gives y=152, heading=2, req_valid=0.
- Moving L with leg_l dropping to 0 and no request -> state BLOCKED, moving=0, position frozen. Then a press of down with leg_d=1 -> y+2, MOVING.
- WRAP_EN=0, x=598, moving R, 3 ticks -> 600 then held; step_done stays 0 on the held ticks. Rerun with WRAP_EN=1 -> 600 then 150.
- freeze=1 across 4 ticks while right pressed -> position unchanged, request retained. freeze=0 plus tick -> step taken.
- Assert rst mid-sequence, asynchronously between clk edges -> outputs return to 360/154, heading=0, moving=0 immediately.

Source files
------------

// File: rtl/pacman_motion_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pacman_motion_ctrl
// Function : Tick-driven sprite motion with buffered turn requests and clamp/wrap edges.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pacman_motion_ctrl #(
   parameter int H_MIN   = 150,
   parameter int H_MAX   = 630,
   parameter int V_MIN   = 34,
   parameter int V_MAX   = 514,
   parameter int SPRITE  = 30,
   parameter int STEP    = 2,
   parameter int START_X = 360,
   parameter int START_Y = 154,
   parameter int WRAP_EN = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       freeze,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       leg_l,
   input  logic       leg_r,
   input  logic       leg_u,
   input  logic       leg_d,
   output logic [9:0] pm_xpos,
   output logic [9:0] pm_ypos,
   output logic [1:0] heading,
   output logic       moveleft,
   output logic       moving,
   output logic       step_done
);

   localparam logic [10:0] C_X_MIN = 11'(H_MIN);
   localparam logic [10:0] C_X_MAX = 11'(H_MAX - SPRITE);
   localparam logic [10:0] C_Y_MIN = 11'(V_MIN);
   localparam logic [10:0] C_Y_MAX = 11'(V_MAX - SPRITE);
   localparam logic [10:0] C_STEP  = 11'(STEP);
   localparam bit          C_WRAP  = (WRAP_EN != 0);

   localparam logic [1:0] C_DIR_R = 2'd0;
   localparam logic [1:0] C_DIR_L = 2'd1;
   localparam logic [1:0] C_DIR_U = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MOVING  = 2'd1,
      ST_BLOCKED = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] xpos_q, xpos_d;
   logic [9:0] ypos_q, ypos_d;
   logic [1:0] heading_q, heading_d;
   logic       moveleft_q, moveleft_d;
   logic       step_done_q, step_done_d;
   logic       req_valid_q, req_valid_d;
   logic [1:0] req_dir_q, req_dir_d;

   logic       w_press;
   logic [1:0] w_press_dir;
   logic       w_eff_valid;
   logic [1:0] w_eff_dir;
   logic [3:0] w_leg_vec;
   logic       w_do_move;
   logic [1:0] w_move_dir;
   logic [10:0] w_x_ext, w_y_ext, w_x_new, w_y_new;

   always_comb begin
      w_press     = right | left | up | down;
      w_press_dir = right ? 2'd0 : left ? 2'd1 : up ? 2'd2 : 2'd3;
      w_eff_valid = w_press | req_valid_q;
      w_eff_dir   = w_press ? w_press_dir : req_dir_q;
      w_leg_vec   = {leg_d, leg_u, leg_l, leg_r};

      state_d     = state_q;
      heading_d   = heading_q;
      moveleft_d  = moveleft_q;
      step_done_d = 1'b0;
      req_valid_d = w_press ? 1'b1 : req_valid_q;
      req_dir_d   = w_press ? w_press_dir : req_dir_q;
      w_do_move   = 1'b0;
      w_move_dir  = heading_q;

      if (tick && !freeze) begin
         if (w_eff_valid && w_leg_vec[w_eff_dir]) begin
            w_do_move   = 1'b1;
            w_move_dir  = w_eff_dir;
            heading_d   = w_eff_dir;
            req_valid_d = 1'b0;
            if (w_eff_dir == C_DIR_R) moveleft_d = 1'b0;
            else if (w_eff_dir == C_DIR_L) moveleft_d = 1'b1;
         end else if (state_q != ST_IDLE && w_leg_vec[heading_q]) begin
            w_do_move = 1'b1;
         end
         if (w_do_move) state_d = ST_MOVING;
         else if (state_q == ST_MOVING) state_d = ST_BLOCKED;
      end

      // Underflow is avoided by testing against MIN+STEP before subtracting.
      w_x_ext = {1'b0, xpos_q};
      w_y_ext = {1'b0, ypos_q};
      w_x_new = w_x_ext;
      w_y_new = w_y_ext;
      if (w_do_move) begin
         case (w_move_dir)
            C_DIR_R: w_x_new = (w_x_ext + C_STEP > C_X_MAX) ? (C_WRAP ? C_X_MIN : C_X_MAX)
                                                              : w_x_ext + C_STEP;
            C_DIR_L: w_x_new = (w_x_ext < C_X_MIN + C_STEP) ? (C_WRAP ? C_X_MAX : C_X_MIN)
                                                             : w_x_ext - C_STEP;
            C_DIR_U: w_y_new = (w_y_ext < C_Y_MIN + C_STEP) ? (C_WRAP ? C_Y_MAX : C_Y_MIN)
                                                             : w_y_ext - C_STEP;
            default: w_y_new = (w_y_ext + C_STEP > C_Y_MAX) ? (C_WRAP ? C_Y_MIN : C_Y_MAX)
                                                              : w_y_ext + C_STEP;
         endcase
      end
      xpos_d      = w_x_new[9:0];
      ypos_d      = w_y_new[9:0];
      step_done_d = (w_x_new != w_x_ext) || (w_y_new != w_y_ext);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         xpos_q      <= 10'(START_X);
         ypos_q      <= 10'(START_Y);
         heading_q   <= 2'd0;
         moveleft_q  <= 1'b0;
         step_done_q <= 1'b0;
         req_valid_q <= 1'b0;
         req_dir_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         xpos_q      <= xpos_d;
         ypos_q      <= ypos_d;
         heading_q   <= heading_d;
         moveleft_q  <= moveleft_d;
         step_done_q <= step_done_d;
         req_valid_q <= req_valid_d;
         req_dir_q   <= req_dir_d;
      end
   end

   assign pm_xpos   = xpos_q;
   assign pm_ypos   = ypos_q;
   assign heading   = heading_q;
   assign moveleft  = moveleft_q;
   assign moving    = (state_q == ST_MOVING);
   assign step_done = step_done_q;

endmodule

`default_nettype wire

// File: tb/tb_pacman_motion_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_pacman_motion_ctrl
// Function : Scoreboard bench for clamp and wrap instances against a reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pacman_motion_ctrl;

   localparam int c_h_min = 150, c_h_max = 630, c_v_min = 34, c_v_max = 514;
   localparam int c_sprite = 30, c_step = 2, c_start_x = 360, c_start_y = 154;
   localparam int c_idle = 0, c_mov = 1, c_blk = 2;

   typedef struct {
      int x; int y; int head; int left; int mov; int done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0, freeze = 1'b0;
   logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic leg_l = 1'b0, leg_r = 1'b0, leg_u = 1'b0, leg_d = 1'b0;

   logic [9:0] x0, y0, x1, y1;
   logic [1:0] h0, h1;
   logic ml0, ml1, mv0, mv1, sd0, sd1;

   int checks = 0;
   int failures = 0;

   exp_t q_exp0[$];
   exp_t q_exp1[$];

   int m_x[2], m_y[2], m_head[2], m_left[2], m_state[2], m_done[2], m_req[2];

   always #5 clk = ~clk;

   pacman_motion_ctrl #(.WRAP_EN(0)) u_dut_clamp (
      .clk(clk), .rst(rst), .tick(tick), .freeze(freeze),
      .up(up), .down(down), .left(left), .right(right),
      .leg_l(leg_l), .leg_r(leg_r), .leg_u(leg_u), .leg_d(leg_d),
      .pm_xpos(x0), .pm_ypos(y0), .heading(h0), .moveleft(ml0),
      .moving(mv0), .step_done(sd0)
   );

   pacman_motion_ctrl #(.WRAP_EN(1)) u_dut_wrap (
      .clk(clk), .rst(rst), .tick(tick), .freeze(freeze),
      .up(up), .down(down), .left(left), .right(right),
      .leg_l(leg_l), .leg_r(leg_r), .leg_u(leg_u), .leg_d(leg_d),
      .pm_xpos(x1), .pm_ypos(y1), .heading(h1), .moveleft(ml1),
      .moving(mv1), .step_done(sd1)
   );

   // One axis move: overshooting a bound clamps to it, or jumps to the opposite bound when wrapping.
   function automatic int axis_move(int v, int delta, int lo, int hi, bit wrap);
      int n;
      n = v + delta;
      if (n > hi) return wrap ? lo : hi;
      if (n < lo) return wrap ? hi : lo;
      return n;
   endfunction

   task automatic model_reset(int i);
      m_x[i] = c_start_x; m_y[i] = c_start_y; m_head[i] = 0; m_left[i] = 0;
      m_state[i] = c_idle; m_done[i] = 0; m_req[i] = -1;
   endtask

   task automatic model_cycle(int i, bit [3:0] btn, bit tk, bit fz, bit [3:0] leg);
      int pd, eff, dir, ox, oy;
      bit wrap;
      wrap = (i == 1);
      pd = -1;
      for (int k = 0; k < 4; k++) if (btn[k] && pd < 0) pd = k;
      eff = (pd >= 0) ? pd : m_req[i];
      if (pd >= 0) m_req[i] = pd;
      m_done[i] = 0;
      if (tk && !fz) begin
         dir = -1;
         if (eff >= 0 && leg[eff]) begin
            dir = eff;
            m_head[i] = eff;
            m_req[i] = -1;
            if (eff == 0) m_left[i] = 0;
            if (eff == 1) m_left[i] = 1;
         end else if (m_state[i] != c_idle && leg[m_head[i]]) begin
            dir = m_head[i];
         end
         if (dir >= 0) begin
            ox = m_x[i]; oy = m_y[i];
            case (dir)
               0: m_x[i] = axis_move(ox, c_step, c_h_min, c_h_max - c_sprite, wrap);
               1: m_x[i] = axis_move(ox, -c_step, c_h_min, c_h_max - c_sprite, wrap);
               2: m_y[i] = axis_move(oy, -c_step, c_v_min, c_v_max - c_sprite, wrap);
               default: m_y[i] = axis_move(oy, c_step, c_v_min, c_v_max - c_sprite, wrap);
            endcase
            m_done[i] = (ox != m_x[i] || oy != m_y[i]) ? 1 : 0;
            m_state[i] = c_mov;
         end else if (m_state[i] == c_mov) begin
            m_state[i] = c_blk;
         end
      end
   endtask

   function automatic exp_t model_snapshot(int i);
      exp_t e;
      e.x = m_x[i]; e.y = m_y[i]; e.head = m_head[i]; e.left = m_left[i];
      e.mov = (m_state[i] == c_mov) ? 1 : 0; e.done = m_done[i];
      return e;
   endfunction

   task automatic check_out(string nm, exp_t e, int x, int y, int h, int l, int mv, int d);
      checks++;
      if (e.x != x || e.y != y || e.head != h || e.left != l || e.mov != mv || e.done != d) begin
         failures++;
         $display("FAIL %s t=%0t got x=%0d y=%0d hd=%0d ml=%0d mv=%0d sd=%0d exp x=%0d y=%0d hd=%0d ml=%0d mv=%0d sd=%0d",
                  nm, $time, x, y, h, l, mv, d, e.x, e.y, e.head, e.left, e.mov, e.done);
      end
   endtask

   // Drive one cycle of stimulus and queue the response expected after the next edge.
   task automatic drive(bit [3:0] btn, bit tk, bit fz, bit [3:0] leg);
      @(posedge clk);
      #2;
      rst = 1'b0;
      right = btn[0]; left = btn[1]; up = btn[2]; down = btn[3];
      tick = tk; freeze = fz;
      leg_r = leg[0]; leg_l = leg[1]; leg_u = leg[2]; leg_d = leg[3];
      for (int i = 0; i < 2; i++) model_cycle(i, btn, tk, fz, leg);
      q_exp0.push_back(model_snapshot(0));
      q_exp1.push_back(model_snapshot(1));
   endtask

   // Assert reset between edges and verify outputs react without waiting for a clock.
   task automatic async_reset();
      exp_t e;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) model_reset(i);
      e = model_snapshot(0);
      check_out("async_rst_clamp", e, int'(x0), int'(y0), int'(h0), int'(ml0), int'(mv0), int'(sd0));
      check_out("async_rst_wrap", e, int'(x1), int'(y1), int'(h1), int'(ml1), int'(mv1), int'(sd1));
      q_exp0.push_back(model_snapshot(0));
      q_exp1.push_back(model_snapshot(1));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp0.size() > 0) begin
            e = q_exp0.pop_front();
            check_out("clamp", e, int'(x0), int'(y0), int'(h0), int'(ml0), int'(mv0), int'(sd0));
         end
         if (q_exp1.size() > 0) begin
            e = q_exp1.pop_front();
            check_out("wrap", e, int'(x1), int'(y1), int'(h1), int'(ml1), int'(mv1), int'(sd1));
         end
      end
   end

   initial begin : stimulus
      bit [3:0] btn, leg;
      for (int i = 0; i < 2; i++) model_reset(i);
      #12;
      check_out("reset_clamp", model_snapshot(0), int'(x0), int'(y0), int'(h0), int'(ml0), int'(mv0), int'(sd0));
      check_out("reset_wrap", model_snapshot(1), int'(x1), int'(y1), int'(h1), int'(ml1), int'(mv1), int'(sd1));

      // Right press then five ticks.
      drive(4'b0001, 1'b0, 1'b0, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         drive(4'b0000, 1'b1, 1'b0, 4'b0001);
         drive(4'b0000, 1'b0, 1'b0, 4'b0001);
      end
      // Up request held pending while illegal, then taken.
      drive(4'b0100, 1'b0, 1'b0, 4'b0001);
      for (int k = 0; k < 3; k++) drive(4'b0000, 1'b1, 1'b0, 4'b0001);
      drive(4'b0000, 1'b1, 1'b0, 4'b0101);
      // Turn left, get blocked, escape downward.
      drive(4'b0010, 1'b1, 1'b0, 4'b0010);
      drive(4'b0000, 1'b1, 1'b0, 4'b0010);
      drive(4'b0000, 1'b1, 1'b0, 4'b0000);
      drive(4'b0000, 1'b1, 1'b0, 4'b0000);
      drive(4'b1000, 1'b1, 1'b0, 4'b1000);
      // Long runs to every edge: clamp holds, wrap jumps across.
      for (int d = 0; d < 4; d++) begin
         btn = 4'b0001 << d;
         drive(btn, 1'b0, 1'b0, 4'b1111);
         for (int k = 0; k < 260; k++) drive(4'b0000, 1'b1, 1'b0, 4'b1111);
      end
      // Freeze drops ticks while the right request is latched.
      drive(4'b0010, 1'b1, 1'b0, 4'b1111);
      for (int k = 0; k < 4; k++) drive(4'b0001, 1'b1, 1'b1, 4'b1111);
      drive(4'b0000, 1'b0, 1'b0, 4'b1111);
      drive(4'b0000, 1'b1, 1'b0, 4'b1111);
      drive(4'b0000, 1'b1, 1'b0, 4'b1111);
      async_reset();
      drive(4'b0000, 1'b1, 1'b0, 4'b1111);
      // Randomised traffic with a reset dropped in the middle.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 4; k++) begin
            btn[k] = ($urandom_range(0, 9) == 0);
            leg[k] = ($urandom_range(0, 3) != 0);
         end
         if (c == 1500) async_reset();
         else drive(btn, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, leg);
      end
      drive(4'b0000, 1'b0, 1'b0, 4'b0000);
      repeat (2) @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
